spi_pixel_writer: RTL and testbench

SPI_PIXEL_WRITER -- requirements
Module: spi_pixel_writer

---
 rtl/spi_pixel_writer.sv | 135 +++++++++++++
 tb/tb_spi_pixel_writer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pixel_writer.sv
// spi_pixel_writer: sends a 32-bit pixel-write command as four SPI bytes,
// MSB first, with chip select framed per byte and a recovery gap per frame.
module spi_pixel_writer #(
  parameter int CLK_DIV   = 1,   // Sclk half-period in clock cycles (1..255)
  parameter int BYTE_GAP  = 2,   // CSel-high cycles between bytes (1..255)
  parameter int FRAME_GAP = 16   // idle cycles after the last byte (1..255)
) (
  input  logic        MainClkSrc,
  input  logic        ResetN,
  input  logic        CmdValid,
  input  logic [31:0] CmdData,
  output logic        CmdReady,
  output logic        Sclk,
  output logic        Mosi,
  output logic        CSel,
  output logic        Busy,
  output logic        Done
);

  // Divider reload values: a phase ends when the divider reaches zero.
  localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] BYTE_LOAD  = 8'(BYTE_GAP - 1);
  localparam logic [7:0] FRAME_LOAD = 8'(FRAME_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIT_LO,
    ST_BIT_HI,
    ST_BYTE_GAP,
    ST_FRAME_GAP
  } stateT;

  stateT       state, nextState;
  logic [31:0] shiftReg, nextShift;
  logic [2:0]  bitCnt, nextBitCnt;
  logic [1:0]  byteCnt, nextByteCnt;
  logic [7:0]  divCnt, nextDivCnt;
  logic        nextSclk, nextMosi, nextCSel, nextDone;
  logic        phaseEnd, inBit;

  assign phaseEnd = (divCnt == 8'd0);
  assign CmdReady = (state == ST_IDLE);
  assign Busy     = (state != ST_IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge MainClkSrc or negedge ResetN) begin
    if (!ResetN) state <= ST_IDLE;
    else         state <= nextState;
  end

  // Next-state logic: each phase lasts until the divider expires.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:      if (CmdValid) nextState = ST_BIT_LO;
      ST_BIT_LO:    if (phaseEnd) nextState = ST_BIT_HI;
      ST_BIT_HI:
        if (phaseEnd) begin
          if (bitCnt != 3'd7)       nextState = ST_BIT_LO;
          else if (byteCnt != 2'd3) nextState = ST_BYTE_GAP;
          else                      nextState = ST_FRAME_GAP;
        end
      ST_BYTE_GAP:  if (phaseEnd) nextState = ST_BIT_LO;
      ST_FRAME_GAP: if (phaseEnd) nextState = ST_IDLE;
      default:      nextState = ST_IDLE;
    endcase
  end

  // Datapath next values: load on handshake, shift after each Sclk high
  // phase, count bytes across gaps, reload the divider on phase change.
  always_comb begin
    nextShift   = shiftReg;
    nextBitCnt  = bitCnt;
    nextByteCnt = byteCnt;
    nextDivCnt  = divCnt;
    if (state == ST_IDLE && CmdValid) begin
      nextShift   = CmdData;
      nextBitCnt  = 3'd0;
      nextByteCnt = 2'd0;
    end
    if (state == ST_BIT_HI && phaseEnd) begin
      nextShift  = {shiftReg[30:0], 1'b0};
      nextBitCnt = bitCnt + 3'd1;
    end
    if (state == ST_BYTE_GAP && phaseEnd) nextByteCnt = byteCnt + 2'd1;
    if (nextState != state) begin
      case (nextState)
        ST_BIT_LO, ST_BIT_HI: nextDivCnt = DIV_LOAD;
        ST_BYTE_GAP:          nextDivCnt = BYTE_LOAD;
        ST_FRAME_GAP:         nextDivCnt = FRAME_LOAD;
        default:              nextDivCnt = 8'd0;
      endcase
    end else if (!phaseEnd) begin
      nextDivCnt = divCnt - 8'd1;
    end
  end

  // Output decode from the upcoming state so the pins come straight off flops.
  always_comb begin
    inBit    = (nextState == ST_BIT_LO) || (nextState == ST_BIT_HI);
    nextCSel = !inBit;
    nextSclk = (nextState != ST_BIT_LO);
    nextMosi = inBit && nextShift[31];
    nextDone = (state == ST_BIT_HI) && (nextState == ST_FRAME_GAP);
  end

  // Datapath and output registers; reset drops CSel and aborts any frame.
  // NOTE: the shift register is reset too, so a restarted block never
  // carries bits from an aborted frame.
  always_ff @(posedge MainClkSrc or negedge ResetN) begin
    if (!ResetN) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      byteCnt  <= '0;
      divCnt   <= '0;
      Sclk     <= 1'b1;
      Mosi     <= 1'b0;
      CSel     <= 1'b1;
      Done     <= 1'b0;
    end else begin
      shiftReg <= nextShift;
      bitCnt   <= nextBitCnt;
      byteCnt  <= nextByteCnt;
      divCnt   <= nextDivCnt;
      Sclk     <= nextSclk;
      Mosi     <= nextMosi;
      CSel     <= nextCSel;
      Done     <= nextDone;
    end
  end

endmodule

// File: tb/tb_spi_pixel_writer.sv
// Testbench for spi_pixel_writer: a default instance and a CLK_DIV=3
// instance, an SPI receiver model per instance, and a protocol watcher.
module tb_spi_pixel_writer;

  logic        mainClkSrc = 1'b0;
  logic        resetN;
  logic        cmdValid0, cmdValid1;
  logic [31:0] cmdData0, cmdData1;
  logic [1:0]  cmdReady, sclk, mosi, csel, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 mainClkSrc = ~mainClkSrc;

  spi_pixel_writer u0 (
    .MainClkSrc(mainClkSrc), .ResetN(resetN), .CmdValid(cmdValid0), .CmdData(cmdData0),
    .CmdReady(cmdReady[0]), .Sclk(sclk[0]), .Mosi(mosi[0]), .CSel(csel[0]),
    .Busy(busy[0]), .Done(done[0])
  );

  spi_pixel_writer #(.CLK_DIV(3)) u1 (
    .MainClkSrc(mainClkSrc), .ResetN(resetN), .CmdValid(cmdValid1), .CmdData(cmdData1),
    .CmdReady(cmdReady[1]), .Sclk(sclk[1]), .Mosi(mosi[1]), .CSel(csel[1]),
    .Busy(busy[1]), .Done(done[1])
  );

  // Receiver model and protocol watcher state, one slot per instance.
  logic [7:0] rxBytes [2][256];
  int         rxCnt [2]      = '{0, 0};
  int         cselLow [2][256];
  int         cselLowCnt [2] = '{0, 0};
  int         cselGap [2][256];
  int         cselGapCnt [2] = '{0, 0};
  int         doneCnt [2]    = '{0, 0};
  int         sclkLoRuns [2] = '{0, 0};
  int         sclkHiRuns [2] = '{0, 0};
  int         sclkBad [2]    = '{0, 0};
  int         lowRun [2], highRun [2], sclkLoRun [2], sclkHiRun [2], bitsIn [2];
  logic [7:0] shiftIn [2];
  logic       prevSclk [2], prevMosi [2], prevCsel [2], prevDone [2];

  // Sample every output on the falling edge: assemble bytes on Sclk rises,
  // measure CSel and Sclk run lengths, and watch for protocol violations.
  always @(negedge mainClkSrc) begin
    for (int k = 0; k < 2; k++) begin
      if (resetN !== 1'b1) begin
        bitsIn[k] = 0; lowRun[k] = 0; highRun[k] = 0; sclkLoRun[k] = 0; sclkHiRun[k] = 0;
      end else begin
        checks += 3;
        if (sclk[k] !== prevSclk[k] && csel[k] !== 1'b0) begin
          failures++;
          $display("FAIL proto_sclk_edge_unselected inst%0d: sclk %b->%b with csel=%b at %0t", k, prevSclk[k], sclk[k], csel[k], $time);
        end
        if (mosi[k] !== prevMosi[k] && !csel[k] && !prevCsel[k] && !(prevSclk[k] && !sclk[k])) begin
          failures++;
          $display("FAIL proto_mosi_unstable inst%0d: mosi %b->%b with sclk %b->%b at %0t", k, prevMosi[k], mosi[k], prevSclk[k], sclk[k], $time);
        end
        if (done[k] && prevDone[k]) begin
          failures++;
          $display("FAIL proto_done_width inst%0d: done high 2+ cycles, required 1, at %0t", k, $time);
        end
        if (done[k]) doneCnt[k]++;
        // Byte assembly on Sclk rising while selected.
        if (sclk[k] && !prevSclk[k] && !csel[k]) begin
          shiftIn[k] = {shiftIn[k][6:0], mosi[k]};
          bitsIn[k]++;
          if (bitsIn[k] == 8) begin
            if (rxCnt[k] < 256) rxBytes[k][rxCnt[k]] = shiftIn[k];
            rxCnt[k]++;
            bitsIn[k] = 0;
          end
        end
        // CSel run lengths.
        if (!csel[k]) begin
          if (prevCsel[k]) begin
            if (cselGapCnt[k] < 256) cselGap[k][cselGapCnt[k]] = highRun[k];
            cselGapCnt[k]++;
            lowRun[k] = 1;
          end else lowRun[k]++;
        end else begin
          if (!prevCsel[k]) begin
            if (cselLowCnt[k] < 256) cselLow[k][cselLowCnt[k]] = lowRun[k];
            cselLowCnt[k]++;
            highRun[k] = 1;
          end else highRun[k]++;
        end
        // Sclk phase lengths inside a byte.
        if (!csel[k]) begin
          if (!sclk[k]) begin
            if (prevSclk[k] && !prevCsel[k]) begin
              sclkHiRuns[k]++;
              if (sclkHiRun[k] != ((k == 0) ? 1 : 3)) sclkBad[k]++;
            end
            sclkLoRun[k] = (prevSclk[k] || prevCsel[k]) ? 1 : sclkLoRun[k] + 1;
          end else begin
            if (!prevSclk[k] && !prevCsel[k]) begin
              sclkLoRuns[k]++;
              if (sclkLoRun[k] != ((k == 0) ? 1 : 3)) sclkBad[k]++;
            end
            sclkHiRun[k] = (!prevSclk[k]) ? 1 : sclkHiRun[k] + 1;
          end
        end
      end
      prevSclk[k] = sclk[k]; prevMosi[k] = mosi[k]; prevCsel[k] = csel[k]; prevDone[k] = done[k];
    end
  end

  // Handshake on instance 0; returns at the first falling edge after the
  // accepting clock edge with CmdValid dropped.
  task automatic send0(input logic [31:0] word, output bit ok);
    int w = 0;
    while (cmdReady[0] !== 1'b1 && w < 400) begin
      @(negedge mainClkSrc);
      w++;
    end
    ok = (cmdReady[0] === 1'b1);
    cmdValid0 = 1'b1;
    cmdData0  = word;
    @(negedge mainClkSrc);
    cmdValid0 = 1'b0;
  endtask

  task automatic test_reset();
    cmdValid0 = 1'b1; cmdData0 = 32'hFFFF_FFFF;
    cmdValid1 = 1'b1; cmdData1 = 32'hFFFF_FFFF;
    repeat (3) @(negedge mainClkSrc);
    checks++;
    if ({csel[0], sclk[0], mosi[0], busy[0], done[0], cmdReady[0]} !== 6'b110001) begin
      failures++;
      $display("FAIL reset_outputs inst0: {csel,sclk,mosi,busy,done,ready}=%b required 110001", {csel[0], sclk[0], mosi[0], busy[0], done[0], cmdReady[0]});
    end
    checks++;
    if ({csel[1], sclk[1], mosi[1], busy[1], cmdReady[1]} !== 5'b11001) begin
      failures++;
      $display("FAIL reset_outputs inst1: {csel,sclk,mosi,busy,ready}=%b required 11001", {csel[1], sclk[1], mosi[1], busy[1], cmdReady[1]});
    end
    cmdValid0 = 1'b0; cmdValid1 = 1'b0;
    @(negedge mainClkSrc);
    resetN = 1'b1;
    repeat (2) @(negedge mainClkSrc);
    checks++;
    if (busy !== 2'b00 || csel !== 2'b11) begin
      failures++;
      $display("FAIL reset_no_handshake: busy=%b csel=%b required busy=00 csel=11", busy, csel);
    end
  endtask

  task automatic test_basic_frame();
    logic [31:0] word = 32'h41C0_C0C0;
    int base = rxCnt[0], lb = cselLowCnt[0], gb = cselGapCnt[0], d0 = doneCnt[0];
    int j = 0, doneJ = -1;
    logic busyAtDone = 1'b0;
    bit ok;
    send0(word, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_handshake_timeout: ready never seen"); end
    while (cmdReady[0] !== 1'b1 && j < 400) begin
      if (done[0] === 1'b1 && doneJ < 0) begin doneJ = j; busyAtDone = busy[0]; end
      @(negedge mainClkSrc);
      j++;
    end
    checks++;
    if (j != 86) begin failures++; $display("FAIL basic_ready_latency: got %0d cycles required 86", j); end
    checks++;
    if (doneJ != 70 || busyAtDone !== 1'b1) begin
      failures++;
      $display("FAIL basic_done_position: done at cycle %0d busy=%b required cycle 70 busy=1", doneJ, busyAtDone);
    end
    checks++;
    if (doneCnt[0] - d0 != 1) begin failures++; $display("FAIL basic_done_count: got %0d required 1", doneCnt[0] - d0); end
    checks++;
    if (rxCnt[0] - base != 4) begin
      failures++;
      $display("FAIL basic_byte_count: got %0d required 4", rxCnt[0] - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rxBytes[0][base + i] !== word[31 - 8 * i -: 8]) begin
          failures++;
          $display("FAIL basic_byte%0d: got %h required %h", i, rxBytes[0][base + i], word[31 - 8 * i -: 8]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cselLow[0][lb + i] != 16) begin
        failures++;
        $display("FAIL basic_csel_low%0d: got %0d cycles required 16", i, cselLow[0][lb + i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (cselGap[0][gb + i] != 2) begin
        failures++;
        $display("FAIL basic_byte_gap%0d: got %0d cycles required 2", i, cselGap[0][gb + i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] words = {32'h41C0_C0C0, 32'h4103_0303};
    int base = rxCnt[0], d0 = doneCnt[0];
    int j = 0, doneJ = -1, startJ = -1, readyCnt = 0, w = 0;
    while (cmdReady[0] !== 1'b1 && w < 400) begin @(negedge mainClkSrc); w++; end
    cmdValid0 = 1'b1; cmdData0 = 32'h41C0_C0C0;
    @(negedge mainClkSrc);
    cmdData0 = 32'h4103_0303;
    while (j < 400 && !(startJ >= 0 && cmdReady[0] === 1'b1)) begin
      if (done[0] === 1'b1 && doneJ < 0) doneJ = j;
      if (cmdReady[0] === 1'b1) readyCnt++;
      if (doneJ >= 0 && startJ < 0 && csel[0] === 1'b0) begin startJ = j; cmdValid0 = 1'b0; end
      @(negedge mainClkSrc);
      j++;
    end
    cmdValid0 = 1'b0;
    checks++;
    if (startJ - doneJ != 17) begin
      failures++;
      $display("FAIL b2b_restart_gap: second frame %0d cycles after done, required 17", startJ - doneJ);
    end
    checks++;
    if (readyCnt != 1) begin failures++; $display("FAIL b2b_ready_cycles: got %0d ready cycles between frames, required 1", readyCnt); end
    checks++;
    if (j != 173) begin failures++; $display("FAIL b2b_total_latency: got %0d cycles required 173", j); end
    checks++;
    if (doneCnt[0] - d0 != 2) begin failures++; $display("FAIL b2b_done_count: got %0d required 2", doneCnt[0] - d0); end
    checks++;
    if (rxCnt[0] - base != 8) begin
      failures++;
      $display("FAIL b2b_byte_count: got %0d required 8", rxCnt[0] - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rxBytes[0][base + i] !== words[63 - 8 * i -: 8]) begin
          failures++;
          $display("FAIL b2b_byte%0d: got %h required %h", i, rxBytes[0][base + i], words[63 - 8 * i -: 8]);
        end
      end
    end
  endtask

  task automatic test_clk_div3();
    logic [31:0] word = 32'hA53C_0FF0;
    int base = rxCnt[1], lb = cselLowCnt[1], d0 = doneCnt[1];
    int lo0 = sclkLoRuns[1], hi0 = sclkHiRuns[1], bad0 = sclkBad[1];
    int j = 0, doneJ = -1, w = 0;
    while (cmdReady[1] !== 1'b1 && w < 400) begin @(negedge mainClkSrc); w++; end
    cmdValid1 = 1'b1; cmdData1 = word;
    @(negedge mainClkSrc);
    cmdValid1 = 1'b0;
    while (cmdReady[1] !== 1'b1 && j < 600) begin
      if (done[1] === 1'b1 && doneJ < 0) doneJ = j;
      @(negedge mainClkSrc);
      j++;
    end
    checks++;
    if (j != 214 || doneJ != 198) begin
      failures++;
      $display("FAIL div3_latency: ready after %0d done at %0d, required 214 and 198", j, doneJ);
    end
    checks++;
    if (doneCnt[1] - d0 != 1) begin failures++; $display("FAIL div3_done_count: got %0d required 1", doneCnt[1] - d0); end
    checks++;
    if (sclkLoRuns[1] - lo0 != 32 || sclkHiRuns[1] - hi0 != 28 || sclkBad[1] != bad0) begin
      failures++;
      $display("FAIL div3_sclk_phases: lo=%0d hi=%0d bad=%0d required lo=32 hi=28 bad=0",
               sclkLoRuns[1] - lo0, sclkHiRuns[1] - hi0, sclkBad[1] - bad0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cselLow[1][lb + i] != 48) begin
        failures++;
        $display("FAIL div3_csel_low%0d: got %0d cycles required 48", i, cselLow[1][lb + i]);
      end
      checks++;
      if (rxCnt[1] - base != 4 || rxBytes[1][base + i] !== word[31 - 8 * i -: 8]) begin
        failures++;
        $display("FAIL div3_byte%0d: got %h (count %0d) required %h", i, rxBytes[1][base + i], rxCnt[1] - base, word[31 - 8 * i -: 8]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] word = 32'h1234_5678;
    int base, d0 = doneCnt[0], j = 0;
    bit ok;
    send0(32'hFFFF_FFFF, ok);
    repeat (45) @(negedge mainClkSrc);   // byte 2, bit 4, Sclk high phase
    checks++;
    if (!ok || {csel[0], sclk[0], mosi[0]} !== 3'b011) begin
      failures++;
      $display("FAIL midreset_position: {csel,sclk,mosi}=%b required 011", {csel[0], sclk[0], mosi[0]});
    end
    #1 resetN = 1'b0;
    #1;
    checks++;
    if ({csel[0], sclk[0], mosi[0], busy[0], done[0]} !== 5'b11000) begin
      failures++;
      $display("FAIL midreset_async_outputs: {csel,sclk,mosi,busy,done}=%b required 11000", {csel[0], sclk[0], mosi[0], busy[0], done[0]});
    end
    repeat (2) @(negedge mainClkSrc);
    resetN = 1'b1;
    @(negedge mainClkSrc);
    checks++;
    if (doneCnt[0] != d0 || cmdReady[0] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_no_done: done pulses=%0d ready=%b required 0 and 1", doneCnt[0] - d0, cmdReady[0]);
    end
    base = rxCnt[0];
    send0(word, ok);
    while (cmdReady[0] !== 1'b1 && j < 400) begin @(negedge mainClkSrc); j++; end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rxCnt[0] - base != 4 || rxBytes[0][base + i] !== word[31 - 8 * i -: 8]) begin
        failures++;
        $display("FAIL midreset_next_byte%0d: got %h (count %0d) required %h", i, rxBytes[0][base + i], rxCnt[0] - base, word[31 - 8 * i -: 8]);
      end
    end
  endtask

  task automatic test_data_change();
    logic [31:0] word = 32'hDEAD_BEEF;
    int base = rxCnt[0], j = 0;
    bit ok;
    send0(word, ok);
    while (cmdReady[0] !== 1'b1 && j < 400) begin
      cmdData0 = cmdData0 ^ 32'h9E37_79B9 ^ 32'(j);
      @(negedge mainClkSrc);
      j++;
    end
    checks++;
    if (!ok || j != 86) begin failures++; $display("FAIL datachg_latency: got %0d cycles required 86", j); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rxCnt[0] - base != 4 || rxBytes[0][base + i] !== word[31 - 8 * i -: 8]) begin
        failures++;
        $display("FAIL datachg_byte%0d: got %h (count %0d) required %h", i, rxBytes[0][base + i], rxCnt[0] - base, word[31 - 8 * i -: 8]);
      end
    end
  endtask

  initial begin
    resetN = 1'b0;
    cmdValid0 = 1'b0; cmdData0 = '0;
    cmdValid1 = 1'b0; cmdData1 = '0;
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_clk_div3();
    test_reset_midframe();
    test_data_change();
    repeat (4) @(negedge mainClkSrc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
